// File: rtl/noc_pkg.sv
// Shared NoC definitions: default link geometry and the flit type used by
// routers, the receive side and this transmit block.
package noc_pkg;

    localparam int FLIT_W_DEF    = 16;
    localparam int CREDITS_DEF   = 4;
    localparam int BUF_DEPTH_DEF = 4;

    typedef logic [FLIT_W_DEF-1:0] flit_t;

    // Width of a counter that must hold every value 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/noc_credit_tx_if.sv
// Bundle between the local flit source / downstream router and noc_credit_tx.
//
// Handshake semantics:
//   Source side is valid/ready: a flit moves on a rising edge where
//   in_valid_i & in_ready_o. Once in_valid_i is raised the source holds it and
//   in_data_i stable until that edge. in_ready_o depends only on registered
//   state, never on in_valid_i.
//   Downstream side is valid/credit: valid_o marks data_o for exactly one
//   cycle and has no ready; it is only raised while a credit is held.
//   credit_i is a one-cycle pulse returning one downstream buffer slot.
interface noc_credit_tx_if
    import noc_pkg::*;
#(
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int CREDITS   = CREDITS_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
);
    localparam int CNT_W  = cnt_width(CREDITS);
    localparam int FCNT_W = cnt_width(BUF_DEPTH);

    logic [FLIT_W-1:0] in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [FLIT_W-1:0] data_o;
    logic              valid_o;
    logic              credit_i;
    logic [CNT_W-1:0]  credit_cnt_o;
    logic [FCNT_W-1:0] fifo_cnt_o;
    logic              credit_err_o;

    // Environment side: drives the source flit and downstream credit returns.
    modport master (
        output in_data_i, in_valid_i, credit_i,
        input  in_ready_o, data_o, valid_o, credit_cnt_o, fifo_cnt_o, credit_err_o
    );

    // Transmit block side.
    modport slave (
        input  in_data_i, in_valid_i, credit_i,
        output in_ready_o, data_o, valid_o, credit_cnt_o, fifo_cnt_o, credit_err_o
    );

endinterface

// File: rtl/noc_flit_fifo.sv
// Small circular flit buffer. Head flit is read straight from the storage
// registers so the consumer can register it on the pop edge.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_push,
    input  logic [FLIT_W-1:0]                i_push_data,
    input  logic                             i_pop,
    output logic [FLIT_W-1:0]                o_head,
    output logic                             o_full,
    output logic                             o_empty,
    output logic [cnt_width(BUF_DEPTH)-1:0]  o_count
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = cnt_width(BUF_DEPTH);

    logic [FLIT_W-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage write; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; BUF_DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(BUF_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/noc_credit_tx.sv
// Transmit end of a credit-based NoC link: buffers local flits and forwards
// them downstream one per cycle while a downstream buffer credit is held.
module noc_credit_tx
    import noc_pkg::*;
#(
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int CREDITS   = CREDITS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    noc_credit_tx_if.slave bus
);
    localparam int CNT_W = cnt_width(CREDITS);

    logic [FLIT_W-1:0]               w_head;
    logic                            w_full;
    logic                            w_empty;
    logic [cnt_width(BUF_DEPTH)-1:0] w_fifo_cnt;
    logic                            w_push;
    logic                            w_send;

    logic [CNT_W-1:0]  r_credit_cnt;
    logic [FLIT_W-1:0] r_data;
    logic              r_valid;
    logic              r_credit_err;

    // Accept only from registered fullness; send only on the registered credit
    // count, so a credit arriving this cycle is usable from the next one.
    assign w_push = bus.in_valid_i && !w_full;
    assign w_send = !w_empty && (r_credit_cnt != '0);

    noc_flit_fifo #(
        .FLIT_W    (FLIT_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (bus.in_data_i),
        .i_pop       (w_send),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_fifo_cnt)
    );

    // Credit count: minus one per send, plus one per returned credit, saturating at CREDITS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit_cnt <= CNT_W'(CREDITS);
        end else if (w_send && !bus.credit_i) begin
            r_credit_cnt <= r_credit_cnt - CNT_W'(1);
        end else if (!w_send && bus.credit_i && (r_credit_cnt != CNT_W'(CREDITS))) begin
            r_credit_cnt <= r_credit_cnt + CNT_W'(1);
        end
    end

    // Sticky flag: downstream returned a credit we never spent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit_err <= 1'b0;
        end else if (!w_send && bus.credit_i && (r_credit_cnt == CNT_W'(CREDITS))) begin
            r_credit_err <= 1'b1;
        end
    end

    // Output register: valid pulses for each sent flit, data holds between sends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_send;
            if (w_send) begin
                r_data <= w_head;
            end
        end
    end

    assign bus.in_ready_o   = !w_full;
    assign bus.data_o       = r_data;
    assign bus.valid_o      = r_valid;
    assign bus.credit_cnt_o = r_credit_cnt;
    assign bus.fifo_cnt_o   = w_fifo_cnt;
    assign bus.credit_err_o = r_credit_err;

endmodule

// File: tb/tb_noc_credit_tx.sv
// Bench for noc_credit_tx with FLIT_W=16, BUF_DEPTH=4, CREDITS=4.
module tb_noc_credit_tx;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        c;
        logic        ev;
        logic [15:0] ed;
        logic [2:0]  ec;
        logic [2:0]  ef;
        logic        er;
        logic        ee;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    vec_t        vec_q[$];
    logic [15:0] exp_q[$];

    noc_credit_tx_if #(.FLIT_W(16), .CREDITS(4), .BUF_DEPTH(4)) bus ();

    noc_credit_tx #(
        .FLIT_W    (16),
        .BUF_DEPTH (4),
        .CREDITS   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [15:0] ed,
                              input logic [2:0] ec, input logic [2:0] ef,
                              input logic er, input logic ee);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'(ev));
        check({tag, "_data"},  32'(bus.data_o), 32'(ed));
        check({tag, "_cnt"},   32'(bus.credit_cnt_o), 32'(ec));
        check({tag, "_fifo"},  32'(bus.fifo_cnt_o), 32'(ef));
        check({tag, "_ready"}, 32'(bus.in_ready_o), 32'(er));
        check({tag, "_err"},   32'(bus.credit_err_o), 32'(ee));
    endtask

    // Driver: apply inputs away from the edge, clock once, sample 1 time unit later.
    task automatic step(input logic v, input logic [15:0] d, input logic c);
        bus.in_valid_i = v;
        bus.in_data_i  = d;
        bus.credit_i   = c;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every downstream flit must be the oldest outstanding expected flit.
    task automatic sb_watch(input string tag);
        logic [15:0] e;
        if (bus.valid_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s_extra: got %0h expected none", tag, bus.data_o);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_order"}, 32'(bus.data_o), 32'(e));
            end
        end
    endtask

    function automatic void add(input logic v, input logic [15:0] d, input logic c,
                                input logic ev, input logic [15:0] ed, input logic [2:0] ec,
                                input logic [2:0] ef, input logic er, input logic ee);
        vec_q.push_back('{v, d, c, ev, ed, ec, ef, er, ee});
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        bus.credit_i   = 1'b0;

        //    v  data      c   ev ed        ec ef er ee
        // single flit: one cycle after acceptance, credit 4->3, then return credit
        add(1, 16'hA5A5, 0,   0, 16'h0000, 4, 1, 1, 0);
        add(0, 16'h0000, 0,   1, 16'hA5A5, 3, 0, 1, 0);
        add(0, 16'h0000, 0,   0, 16'hA5A5, 3, 0, 1, 0);
        add(0, 16'h0000, 1,   0, 16'hA5A5, 4, 0, 1, 0);
        // six flits, no credits returned: four go out, two stay buffered
        add(1, 16'h1001, 0,   0, 16'hA5A5, 4, 1, 1, 0);
        add(1, 16'h1002, 0,   1, 16'h1001, 3, 1, 1, 0);
        add(1, 16'h1003, 0,   1, 16'h1002, 2, 1, 1, 0);
        add(1, 16'h1004, 0,   1, 16'h1003, 1, 1, 1, 0);
        add(1, 16'h1005, 0,   1, 16'h1004, 0, 1, 1, 0);
        add(1, 16'h1006, 0,   0, 16'h1004, 0, 2, 1, 0);
        add(0, 16'h0000, 0,   0, 16'h1004, 0, 2, 1, 0);
        // one credit at zero: count 0->1, flit goes out the following cycle
        add(0, 16'h0000, 1,   0, 16'h1004, 1, 2, 1, 0);
        add(0, 16'h0000, 0,   1, 16'h1005, 0, 1, 1, 0);
        add(0, 16'h0000, 0,   0, 16'h1005, 0, 1, 1, 0);
        // drain last flit (send + credit same cycle keeps count) and refill credits
        add(0, 16'h0000, 1,   0, 16'h1005, 1, 1, 1, 0);
        add(0, 16'h0000, 1,   1, 16'h1006, 1, 0, 1, 0);
        add(0, 16'h0000, 1,   0, 16'h1006, 2, 0, 1, 0);
        add(0, 16'h0000, 1,   0, 16'h1006, 3, 0, 1, 0);
        add(0, 16'h0000, 1,   0, 16'h1006, 4, 0, 1, 0);
        // continuous stream with a credit returned every cycle: back-to-back valid
        add(1, 16'hC001, 0,   0, 16'h1006, 4, 1, 1, 0);
        add(1, 16'hC002, 0,   1, 16'hC001, 3, 1, 1, 0);
        add(1, 16'hC003, 1,   1, 16'hC002, 3, 1, 1, 0);
        add(1, 16'hC004, 1,   1, 16'hC003, 3, 1, 1, 0);
        add(1, 16'hC005, 1,   1, 16'hC004, 3, 1, 1, 0);
        add(0, 16'h0000, 1,   1, 16'hC005, 3, 0, 1, 0);
        add(0, 16'h0000, 1,   0, 16'hC005, 4, 0, 1, 0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_outs("rst", 0, 16'h0000, 4, 0, 1, 0);
        reset = 1'b1;

        foreach (vec_q[i]) begin
            step(vec_q[i].v, vec_q[i].d, vec_q[i].c);
            check_outs($sformatf("v%0d", i), vec_q[i].ev, vec_q[i].ed, vec_q[i].ec,
                       vec_q[i].ef, vec_q[i].er, vec_q[i].ee);
        end

        // full FIFO: held flit accepted only after a pop frees a slot
        for (int i = 0; i < 9; i++) exp_q.push_back(16'hB000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            step(1, 16'hB000 + 16'(i), 0);
            sb_watch("fill");
        end
        check("fill_fifo",  32'(bus.fifo_cnt_o), 32'd4);
        check("fill_ready", 32'(bus.in_ready_o), 32'd0);
        check("fill_cnt",   32'(bus.credit_cnt_o), 32'd0);
        check("fill_valid", 32'(bus.valid_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1, 16'hB008, 0);
            sb_watch("hold");
            check("hold_fifo",  32'(bus.fifo_cnt_o), 32'd4);
            check("hold_ready", 32'(bus.in_ready_o), 32'd0);
        end
        step(1, 16'hB008, 1);
        sb_watch("cred");
        check("cred_cnt",  32'(bus.credit_cnt_o), 32'd1);
        check("cred_fifo", 32'(bus.fifo_cnt_o), 32'd4);
        check("cred_ready", 32'(bus.in_ready_o), 32'd0);
        step(1, 16'hB008, 0);
        check("pop_valid", 32'(bus.valid_o), 32'd1);
        sb_watch("pop");
        check("pop_fifo",  32'(bus.fifo_cnt_o), 32'd3);
        check("pop_ready", 32'(bus.in_ready_o), 32'd1);
        check("pop_cnt",   32'(bus.credit_cnt_o), 32'd0);
        step(1, 16'hB008, 0);
        sb_watch("acc");
        check("acc_fifo",  32'(bus.fifo_cnt_o), 32'd4);
        check("acc_ready", 32'(bus.in_ready_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 16'h0000, 1);
            sb_watch("drain");
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_cnt",  32'(bus.credit_cnt_o), 32'd4);
        check("drain_fifo", 32'(bus.fifo_cnt_o), 32'd0);
        check("drain_err",  32'(bus.credit_err_o), 32'd0);

        // surplus credit: saturate and flag, flag stays set
        step(0, 16'h0000, 1);
        check("sat_cnt", 32'(bus.credit_cnt_o), 32'd4);
        check("sat_err", 32'(bus.credit_err_o), 32'd1);
        step(0, 16'h0000, 0);
        check("sticky_err", 32'(bus.credit_err_o), 32'd1);

        // asynchronous reset in the middle of a stream
        step(1, 16'hD000, 0);
        step(1, 16'hD001, 0);
        check("mid_valid", 32'(bus.valid_o), 32'd1);
        reset = 1'b0;
        #1;
        check_outs("async", 0, 16'h0000, 4, 0, 1, 0);
        bus.in_valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 16'h0000, 0);
        check_outs("post", 0, 16'h0000, 4, 0, 1, 0);
        step(0, 16'h0000, 0);
        check_outs("post2", 0, 16'h0000, 4, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
